usb_fifo_responder: RTL and testbench

//  Synthesizable device-side model of the FT600-style 16-bit synchronous FIFO bus: the chip end facing our FPGA bus master.

---
 rtl/usb_fifo_pkg.sv | 22 ++
 rtl/usb_fifo_responder_if.sv | 51 +++++
 rtl/usb_sync_fifo.sv | 54 +++++
 rtl/usb_fifo_responder.sv | 139 +++++++++++++
 tb/tb_usb_fifo_responder.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_fifo_pkg.sv
`default_nettype none
// ============================================================================
// usb_fifo_pkg : shared widths, error-bit indices and TX entry type
// Rev 1.0
// ============================================================================
package usb_fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERRUN  = 1;
  localparam int ERR_CONTEND  = 2;
  localparam int ERR_W        = 3;

  typedef struct packed {
    logic [DEF_BE_W-1:0]   be;
    logic [DEF_DATA_W-1:0] data;
  } tx_entry_t;

endpackage
`default_nettype wire

// File: rtl/usb_fifo_responder_if.sv
`default_nettype none
// ============================================================================
// usb_fifo_responder_if : FT600-style FIFO bus plus host-side valid/ready port
// Rev 1.0
// ============================================================================
interface usb_fifo_responder_if #(
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic              RXF_N;
  logic              TXE_N;
  logic              OE_N;
  logic              RD_N;
  logic              WR_N;
  wire  [DATA_W-1:0] DATA;
  wire  [BE_W-1:0]   BE;

  // Each side supplies a value and a drive enable; the shared nets resolve here.
  logic              dev_drive;
  logic [DATA_W-1:0] dev_data;
  logic [BE_W-1:0]   dev_be;
  logic              mst_drive;
  logic [DATA_W-1:0] mst_data;
  logic [BE_W-1:0]   mst_be;

  assign DATA = dev_drive ? dev_data : (mst_drive ? mst_data : 'z);
  assign BE   = dev_drive ? dev_be   : (mst_drive ? mst_be   : 'z);

  logic [DATA_W-1:0] h_tx_data;
  logic              h_tx_valid;
  logic              h_tx_ready;
  logic [DATA_W-1:0] h_rx_data;
  logic [BE_W-1:0]   h_rx_be;
  logic              h_rx_valid;
  logic              h_rx_ready;

  modport slave (
    output RXF_N, TXE_N, dev_drive, dev_data, dev_be,
    input  OE_N, RD_N, WR_N, DATA, BE,
    input  h_tx_data, h_tx_valid, h_rx_ready,
    output h_tx_ready, h_rx_data, h_rx_be, h_rx_valid
  );

  modport master (
    input  RXF_N, TXE_N, DATA, BE,
    output OE_N, RD_N, WR_N, mst_drive, mst_data, mst_be
  );

endinterface
`default_nettype wire

// File: rtl/usb_sync_fifo.sv
`default_nettype none
// ============================================================================
// usb_sync_fifo : single-clock FIFO, power-of-2 depth, async-reset pointers
// Rev 1.0
// ============================================================================
module usb_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/usb_fifo_responder.sv
`default_nettype none
// ============================================================================
// usb_fifo_responder : device side of an FT600-style 16-bit synchronous FIFO bus
// Optional USB_RESP_STATS_EN adds saturating bus pop/push counters.  Rev 1.0
// ============================================================================
module usb_fifo_responder
  import usb_fifo_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  usb_fifo_responder_if.slave  bus,
  output logic                 err_underrun,
  output logic                 err_overrun,
  output logic                 err_contend
`ifdef USB_RESP_STATS_EN
  ,
  output logic [15:0]          stat_rd_cnt,
  output logic [15:0]          stat_wr_cnt
`endif
);
  localparam int BE_W  = DATA_W / 8;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_W  = BE_W + DATA_W;

  logic              r_rxf_n;
  logic              r_txe_n;
  logic              r_tx_ready;
  logic [DATA_W-1:0] r_rdata;
  logic [ERR_W-1:0]  r_err;

  logic [DATA_W-1:0] w_rx_head;
  logic              w_rx_full, w_rx_empty;
  logic [RX_AW:0]    w_rx_count, w_rx_nxt;
  logic              w_rx_push, w_rx_pop, w_rd_req;

  logic [TX_W-1:0]   w_tx_head;
  logic              w_tx_full, w_tx_empty;
  logic [TX_AW:0]    w_tx_count, w_tx_nxt;
  logic              w_tx_push, w_tx_pop, w_wr_req;

  assign w_rd_req  = ~bus.OE_N & ~bus.RD_N;
  assign w_rx_push = bus.h_tx_valid & r_tx_ready & ~w_rx_full;
  assign w_rx_pop  = w_rd_req & ~w_rx_empty;

  // TXE_N is the admission gate, so a host pop in the same edge never frees room early.
  assign w_wr_req  = ~bus.WR_N;
  assign w_tx_push = w_wr_req & bus.OE_N & ~r_txe_n & ~w_tx_full;
  assign w_tx_pop  = bus.h_rx_ready & ~w_tx_empty;

  assign w_rx_nxt = w_rx_count + (RX_AW+1)'(w_rx_push) - (RX_AW+1)'(w_rx_pop);
  assign w_tx_nxt = w_tx_count + (TX_AW+1)'(w_tx_push) - (TX_AW+1)'(w_tx_pop);

  usb_sync_fifo #(.DEPTH(RX_DEPTH), .W(DATA_W)) u_rx_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (bus.h_tx_data),
    .dout  (w_rx_head),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count)
  );

  usb_sync_fifo #(.DEPTH(TX_DEPTH), .W(TX_W)) u_tx_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   ({bus.BE, bus.DATA}),
    .dout  (w_tx_head),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rxf_n    <= 1'b1;
      r_txe_n    <= 1'b1;
      r_tx_ready <= 1'b0;
      r_rdata    <= '0;
      r_err      <= '0;
    end else begin
      r_rxf_n    <= (w_rx_nxt == '0);
      r_txe_n    <= (w_tx_nxt == (TX_AW+1)'(TX_DEPTH));
      r_tx_ready <= (w_rx_nxt != (RX_AW+1)'(RX_DEPTH));
      if (w_rx_pop)
        r_rdata <= w_rx_head;
      if (w_rd_req & w_rx_empty)
        r_err[ERR_UNDERRUN] <= 1'b1;
      if (w_wr_req & r_txe_n)
        r_err[ERR_OVERRUN] <= 1'b1;
      if (w_wr_req & ~bus.OE_N)
        r_err[ERR_CONTEND] <= 1'b1;
    end
  end

  assign bus.RXF_N      = r_rxf_n;
  assign bus.TXE_N      = r_txe_n;
  assign bus.dev_drive  = ~bus.OE_N;
  assign bus.dev_data   = r_rdata;
  assign bus.dev_be     = '1;
  assign bus.h_tx_ready = r_tx_ready;
  assign bus.h_rx_valid = ~w_tx_empty;
  assign bus.h_rx_data  = w_tx_head[DATA_W-1:0];
  assign bus.h_rx_be    = w_tx_head[TX_W-1:DATA_W];

  assign err_underrun = r_err[ERR_UNDERRUN];
  assign err_overrun  = r_err[ERR_OVERRUN];
  assign err_contend  = r_err[ERR_CONTEND];

`ifdef USB_RESP_STATS_EN
  logic [15:0] r_stat_rd_cnt;
  logic [15:0] r_stat_wr_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stat_rd_cnt <= '0;
      r_stat_wr_cnt <= '0;
    end else begin
      if (w_rx_pop && r_stat_rd_cnt != 16'hFFFF)
        r_stat_rd_cnt <= r_stat_rd_cnt + 16'd1;
      if (w_tx_push && r_stat_wr_cnt != 16'hFFFF)
        r_stat_wr_cnt <= r_stat_wr_cnt + 16'd1;
    end
  end

  assign stat_rd_cnt = r_stat_rd_cnt;
  assign stat_wr_cnt = r_stat_wr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_fifo_responder.sv
`default_nettype none
// ============================================================================
// tb_usb_fifo_responder : scoreboard bench for usb_fifo_responder
// Rev 1.0
// ============================================================================
module tb_usb_fifo_responder;
  import usb_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic eu, eo, ec;
`ifdef USB_RESP_STATS_EN
  logic [15:0] src, swc;
`endif

  always #5 clk = ~clk;

  usb_fifo_responder_if bus ();

  usb_fifo_responder #(.RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH), .DATA_W(16)) dut (
    .CLK          (clk),
    .RST          (rst),
    .bus          (bus),
    .err_underrun (eu),
    .err_overrun  (eo),
    .err_contend  (ec)
`ifdef USB_RESP_STATS_EN
    ,
    .stat_rd_cnt  (src),
    .stat_wr_cnt  (swc)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] rx_q[$];
  tx_entry_t   tx_q[$];
  logic [15:0] last_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.OE_N       = 1'b1;
    bus.RD_N       = 1'b1;
    bus.WR_N       = 1'b1;
    bus.mst_drive  = 1'b0;
    bus.mst_data   = '0;
    bus.mst_be     = '0;
    bus.h_tx_valid = 1'b0;
    bus.h_tx_data  = '0;
    bus.h_rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    n_cmp++;
    if ({bus.RXF_N, bus.TXE_N, bus.h_tx_ready, bus.h_rx_valid} !== 4'b1100) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 1100", {bus.RXF_N, bus.TXE_N, bus.h_tx_ready, bus.h_rx_valid});
    end
    n_cmp++;
    if ({eu, eo, ec} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_errs: got %b want 000", {eu, eo, ec});
    end
    bus.OE_N = 1'b0;
    #1;
    n_cmp++;
    if (bus.DATA !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h want 0000", bus.DATA);
    end
    bus.OE_N = 1'b1;
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.RXF_N, bus.TXE_N, bus.h_tx_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL post_reset_flags: got %b want 101", {bus.RXF_N, bus.TXE_N, bus.h_tx_ready});
    end
  endtask

  task automatic test_host_to_bus();
    logic [15:0] exp;
    bus.h_tx_valid = 1'b1;
    bus.h_tx_data  = 16'hA5A5;
    rx_q.push_back(16'hA5A5);
    tick();
    n_cmp++;
    if (bus.RXF_N !== 1'b0) begin
      n_bad++;
      $display("FAIL rxf_after_push: got %b want 0", bus.RXF_N);
    end
    bus.h_tx_data = 16'h1234;
    rx_q.push_back(16'h1234);
    tick();
    bus.h_tx_valid = 1'b0;
    bus.OE_N = 1'b0;
    bus.RD_N = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = rx_q.pop_front();
      last_rd = exp;
      n_cmp++;
      if (bus.DATA !== exp) begin
        n_bad++;
        $display("FAIL read_data[%0d]: got %h want %h", i, bus.DATA, exp);
      end
    end
    n_cmp++;
    if (bus.RXF_N !== 1'b1) begin
      n_bad++;
      $display("FAIL rxf_after_drain: got %b want 1", bus.RXF_N);
    end
    bus.RD_N = 1'b1;
    bus.OE_N = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] d, input logic [1:0] be, input bit expect_ok);
    tx_entry_t e;
    bus.WR_N      = 1'b0;
    bus.mst_drive = 1'b1;
    bus.mst_data  = d;
    bus.mst_be    = be;
    e.data = d;
    e.be   = be;
    if (expect_ok) tx_q.push_back(e);
    tick();
    bus.WR_N      = 1'b1;
    bus.mst_drive = 1'b0;
  endtask

  task automatic drain_tx(input string tag);
    tx_entry_t e;
    int budget;
    budget = 64;
    bus.h_rx_ready = 1'b1;
    while (tx_q.size() > 0 && budget > 0) begin
      if (bus.h_rx_valid === 1'b1) begin
        e = tx_q.pop_front();
        n_cmp++;
        if (bus.h_rx_data !== e.data || bus.h_rx_be !== e.be) begin
          n_bad++;
          $display("FAIL %s_entry: got %h/%b want %h/%b", tag, bus.h_rx_data, bus.h_rx_be, e.data, e.be);
        end
      end
      tick();
      budget--;
    end
    bus.h_rx_ready = 1'b0;
    n_cmp++;
    if (tx_q.size() != 0 || bus.h_rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain: left %0d valid %b want 0 0", tag, tx_q.size(), bus.h_rx_valid);
    end
  endtask

  task automatic test_bus_to_host();
    for (int i = 1; i <= 3; i++)
      bus_write(16'(i), 2'b11, 1'b1);
    drain_tx("b2h");
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < DEPTH; i++)
      bus_write(16'h0100 + 16'(i), (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
    n_cmp++;
    if (bus.TXE_N !== 1'b1 || eo !== 1'b0) begin
      n_bad++;
      $display("FAIL tx_full_flag: txe_n %b ovr %b want 1 0", bus.TXE_N, eo);
    end
    bus_write(16'hDEAD, 2'b11, 1'b0);
    n_cmp++;
    if (eo !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun: got %b want 1", eo);
    end
    drain_tx("full");
    n_cmp++;
    if (bus.TXE_N !== 1'b0) begin
      n_bad++;
      $display("FAIL txe_after_drain: got %b want 0", bus.TXE_N);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    bit popping;
    bit pushing;
    int budget;
    bus.h_tx_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.h_tx_data = 16'hC000 + 16'(i);
      tick();
      rx_q.push_back(16'hC000 + 16'(i));
    end
    // RD_N=0 with OE_N=1 must not pop
    bus.h_tx_valid = 1'b0;
    bus.RD_N = 1'b0;
    tick();
    bus.OE_N = 1'b0;
    budget = 32;
    for (int i = 0; budget > 0 && (rx_q.size() > 0 || i < 4); i++) begin
      pushing = (i < 4);
      popping = (rx_q.size() > 0);
      bus.h_tx_valid = pushing;
      bus.h_tx_data  = 16'hD000 + 16'(i);
      bus.RD_N       = !popping;
      tick();
      if (popping) begin
        exp = rx_q.pop_front();
        last_rd = exp;
        n_cmp++;
        if (bus.DATA !== exp) begin
          n_bad++;
          $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.DATA, exp);
        end
      end
      if (pushing) rx_q.push_back(16'hD000 + 16'(i));
      n_cmp++;
      if (bus.RXF_N !== (rx_q.size() == 0)) begin
        n_bad++;
        $display("FAIL b2b_rxf[%0d]: got %b want %b", i, bus.RXF_N, rx_q.size() == 0);
      end
      budget--;
    end
    bus.h_tx_valid = 1'b0;
    bus.RD_N = 1'b1;
    bus.OE_N = 1'b1;
    n_cmp++;
    if (budget == 0 || eu !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: budget %0d underrun %b want >0 0", budget, eu);
    end
  endtask

  task automatic test_errors();
    bus.OE_N = 1'b0;
    bus.RD_N = 1'b0;
    tick();
    n_cmp++;
    if (eu !== 1'b1 || bus.DATA !== last_rd) begin
      n_bad++;
      $display("FAIL underrun: err %b data %h want 1 %h", eu, bus.DATA, last_rd);
    end
    bus.RD_N = 1'b1;
    n_cmp++;
    if (ec !== 1'b0) begin
      n_bad++;
      $display("FAIL contend_pre: got %b want 0", ec);
    end
    bus.WR_N = 1'b0;
    tick();
    bus.WR_N = 1'b1;
    bus.OE_N = 1'b1;
    tick();
    n_cmp++;
    if (ec !== 1'b1 || bus.h_rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL contend: err %b rx_valid %b want 1 0", ec, bus.h_rx_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    bus_write(16'h7777, 2'b11, 1'b1);
    bus_write(16'h8888, 2'b11, 1'b1);
    bus.h_tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.h_tx_data = 16'hE000 + 16'(i);
      tick();
    end
    bus.h_tx_valid = 1'b0;
    bus.OE_N = 1'b0;
    bus.RD_N = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.RXF_N, bus.TXE_N, bus.h_rx_valid, bus.h_tx_ready, eu, eo, ec} !== 7'b1100000) begin
      n_bad++;
      $display("FAIL mid_reset: got %b want 1100000", {bus.RXF_N, bus.TXE_N, bus.h_rx_valid, bus.h_tx_ready, eu, eo, ec});
    end
    idle();
    #1;
    n_cmp++;
    if (bus.dev_drive !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_release: drive %b want 0", bus.dev_drive);
    end
    rx_q.delete();
    tx_q.delete();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus.RXF_N, bus.TXE_N, bus.h_rx_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL after_mid_reset: got %b want 100", {bus.RXF_N, bus.TXE_N, bus.h_rx_valid});
    end
  endtask

`ifdef USB_RESP_STATS_EN
  task automatic test_stats();
    bus.h_tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.h_tx_data = 16'(i);
      tick();
    end
    bus.h_tx_valid = 1'b0;
    bus.OE_N = 1'b0;
    bus.RD_N = 1'b0;
    repeat (5) tick();
    bus.RD_N = 1'b1;
    bus.OE_N = 1'b1;
    for (int i = 0; i < 3; i++)
      bus_write(16'(i), 2'b11, 1'b1);
    n_cmp++;
    if (src !== 16'd5 || swc !== 16'd3) begin
      n_bad++;
      $display("FAIL stats: got %0d/%0d want 5/3", src, swc);
    end
    force dut.r_stat_rd_cnt = 16'hFFFF;
    #1;
    release dut.r_stat_rd_cnt;
    bus.OE_N = 1'b0;
    bus.RD_N = 1'b0;
    tick();
    bus.RD_N = 1'b1;
    bus.OE_N = 1'b1;
    n_cmp++;
    if (src !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL stats_sat: got %h want ffff", src);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    last_rd = '0;
    test_reset();
    test_host_to_bus();
    test_bus_to_host();
    test_tx_full();
    test_back_to_back();
    test_errors();
    test_reset_mid_burst();
`ifdef USB_RESP_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
